write_grant_scheduler: RTL and testbench
========================================

WRITE_GRANT_SCHEDULER -- requirements
Module: write_grant_scheduler

Interface
REQ-001 Parameter SHALL be: num_of_ports, 16, number of write ports arbitrated (fixed at 16; port index 4 bits).
REQ-002 Port SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-003 Port SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-004 Port SHALL be: sp0_wrr1  input  1  mode (0 = strict priority, 1 = weighted round robin).
REQ-005 Port SHALL be: req  input  num_of_ports  per-port packet-pending request, level.
REQ-006 Port SHALL be: priority_in  input  num_of_ports*3  per-port 3-bit priority; port i in bits [3i+2:3i].
REQ-007 Port SHALL be: xfer_done  input  1  one-cycle pulse at end of the granted port's packet write.
REQ-008 Port SHALL be: grant_valid  output  1  a grant is held.
REQ-009 Port SHALL be: grant_port  output  4  index of granted port, valid while grant_valid.
REQ-010 Port SHALL be: grant_onehot  output  num_of_ports  one-hot of grant_port, all-zero when grant_valid=0.

Function
REQ-011 States SHALL be IDLE and GRANT only.
REQ-012 IDLE: if |req, SHALL compute winner combinationally and, at the next edge, enter GRANT with grant_valid=1, grant_port/grant_onehot registered (1-cycle latency req->grant).
REQ-013 IDLE with req=0 SHALL remain IDLE, outputs zero.
REQ-014 GRANT: grant_port SHALL hold constant until xfer_done, regardless of req, priority_in or sp0_wrr1 changes.
REQ-015 GRANT + xfer_done: next edge SHALL enter IDLE with grant_valid=0; minimum one idle cycle between consecutive grants.
REQ-016 xfer_done in IDLE SHALL be ignored (no state/counter change).
REQ-017 sp0_wrr1 and priority_in SHALL be sampled only in the IDLE arbitration cycle.
REQ-018 SP mode: winner SHALL be requesting port with largest priority value; ties to lowest index.
REQ-019 WRR mode: winner SHALL be first requesting port scanning upward from rr_ptr (4-bit), wrapping 15->0.
REQ-020 WRR grant: if credit==0 or winner!=last_port, credit (4-bit) SHALL load priority[winner]+1 (range 1..8); else credit unchanged; last_port<=winner.
REQ-021 WRR xfer_done: credit SHALL decrement by 1; if result is 0, rr_ptr<=last_port+1 (mod 16), else rr_ptr<=last_port.
REQ-022 SP grant SHALL clear credit to 0 and leave rr_ptr unchanged, so the next WRR grant reloads credit.
REQ-023 grant_onehot SHALL always equal decode of grant_port when grant_valid=1.
REQ-024 Skipped (non-requesting) ports SHALL lose no state other than through REQ-020 reload rule.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, grant_valid=0, grant_port=0, grant_onehot=0, rr_ptr=0, credit=0, last_port=0, in any state including mid-transfer.
REQ-026 First arbitration SHALL occur on the first edge with rst=0 where req!=0 (grant visible the cycle after).

Verification
REQ-027 SP: req=16'h0014, prio[2]=3, prio[4]=5 -> grant_port=4 one cycle later; after xfer_done, grant_valid=0 for 1 cycle, then port 4 again while requesting.
REQ-028 SP tie: req=16'h0009, prio[0]=prio[3]=6 -> grant_port=0.
REQ-029 WRR: req=16'h0003, prio[0]=1, prio[1]=0, xfer_done each grant -> grant sequence 0,0,1,0,0,1.
REQ-030 WRR wrap: rr_ptr=15 reached, req=16'h8001, prio[15]=0 -> grant 15 then 0.
REQ-031 Hold: during GRANT on port 2, drop req[2], raise req[7] prio 7, toggle sp0_wrr1 -> grant_port stays 2 until xfer_done.
REQ-032 Reset mid-GRANT with credit=3 -> next cycle grant_valid=0, outputs zero; subsequent WRR starts at port 0 with fresh credit.

Source files
------------

// File: rtl/write_grant_scheduler.sv
// Packet-write grant scheduler: 16 ports, strict-priority or weighted round robin,
// one grant held until the granted port signals end of its packet write.
module write_grant_scheduler #(
  parameter int num_of_ports = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sp0_wrr1,
  input  logic [num_of_ports-1:0]   req,
  input  logic [num_of_ports*3-1:0] priority_in,
  input  logic                      xfer_done,
  output logic                      grant_valid,
  output logic [3:0]                grant_port,
  output logic [num_of_ports-1:0]   grant_onehot
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] rr_ptr;
  logic [3:0] credit;
  logic [3:0] last_port;
  logic       grant_wrr;

  logic                    sp_found;
  logic [3:0]              sp_win;
  logic [2:0]              sp_prio;
  logic                    wrr_found;
  logic [3:0]              wrr_win;
  logic [2:0]              wrr_prio;
  logic [3:0]              scan_idx;
  logic [3:0]              winner;
  logic [num_of_ports-1:0] onehot_next;

  // Arbitration: both candidates are evaluated every cycle, mode picks one
  always_comb begin
    sp_found  = 1'b0;
    sp_win    = '0;
    sp_prio   = '0;
    wrr_found = 1'b0;
    wrr_win   = '0;
    wrr_prio  = '0;
    scan_idx  = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      if (req[i] && (!sp_found || priority_in[3*i +: 3] > sp_prio)) begin
        sp_found = 1'b1;
        sp_win   = 4'(i);
        sp_prio  = priority_in[3*i +: 3];
      end
    end
    for (int k = 0; k < num_of_ports; k++) begin
      scan_idx = rr_ptr + 4'(k);
      if (!wrr_found && req[scan_idx]) begin
        wrr_found = 1'b1;
        wrr_win   = scan_idx;
        wrr_prio  = priority_in[3*scan_idx +: 3];
      end
    end
    winner = sp0_wrr1 ? wrr_win : sp_win;
    onehot_next = '0;
    onehot_next[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_port   <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
      credit       <= '0;
      last_port    <= '0;
      grant_wrr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state        <= GRANT;
            grant_valid  <= 1'b1;
            grant_port   <= winner;
            grant_onehot <= onehot_next;
            grant_wrr    <= sp0_wrr1;
            if (sp0_wrr1) begin
              // Same port keeps its remaining weight; a new port starts fresh
              if (credit == 4'd0 || wrr_win != last_port)
                credit <= {1'b0, wrr_prio} + 4'd1;
              last_port <= wrr_win;
            end else begin
              credit <= '0;
            end
          end
        end
        GRANT: begin
          if (xfer_done) begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            grant_port   <= '0;
            grant_onehot <= '0;
            if (grant_wrr && credit != 4'd0) begin
              credit <= credit - 4'd1;
              rr_ptr <= (credit == 4'd1) ? last_port + 4'd1 : last_port;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_grant_scheduler.sv
// Directed bench for write_grant_scheduler: SP, ties, WRR weighting and wrap,
// grant hold, reset mid-transfer.
module tb_write_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp0_wrr1;
  logic [15:0] req;
  logic [47:0] priority_in;
  logic        xfer_done;
  logic        grant_valid;
  logic [3:0]  grant_port;
  logic [15:0] grant_onehot;

  int checks   = 0;
  int failures = 0;

  write_grant_scheduler #(.num_of_ports(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sp0_wrr1     (sp0_wrr1),
    .req          (req),
    .priority_in  (priority_in),
    .xfer_done    (xfer_done),
    .grant_valid  (grant_valid),
    .grant_port   (grant_port),
    .grant_onehot (grant_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int port, input logic [2:0] val);
    priority_in[3*port +: 3] = val;
  endtask

  // From IDLE with req set: arbitrate, check the grant, finish the transfer
  task automatic do_grant(input string tag, input logic [3:0] exp_port);
    logic [15:0] oh;
    oh = 16'h0001 << exp_port;
    tick();
    chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    chk({tag, "_port"}, 32'(grant_port), 32'(exp_port));
    chk({tag, "_onehot"}, 32'(grant_onehot), 32'(oh));
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk({tag, "_idle"}, 32'(grant_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sp0_wrr1 = 1'b0; req = '0; priority_in = '0; xfer_done = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_port", 32'(grant_port), 32'd0);
    chk("rst_onehot", 32'(grant_onehot), 32'd0);

    // Idle with no requests; stray xfer_done ignored
    rst = 1'b0;
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    tick();
    chk("idle_valid", 32'(grant_valid), 32'd0);
    chk("idle_onehot", 32'(grant_onehot), 32'd0);

    // Strict priority: port 4 (prio 5) beats port 2 (prio 3)
    set_prio(2, 3'd3); set_prio(4, 3'd5); req = 16'h0014;
    tick();
    chk("sp_port", 32'(grant_port), 32'd4);
    chk("sp_onehot", 32'(grant_onehot), 32'h0010);
    tick();
    chk("sp_hold", 32'(grant_port), 32'd4);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("sp_gap", 32'(grant_valid), 32'd0);
    tick();
    chk("sp_regrant_valid", 32'(grant_valid), 32'd1);
    chk("sp_regrant_port", 32'(grant_port), 32'd4);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("sp_done", 32'(grant_valid), 32'd0);

    // Ties go to lowest index; highest index wins when strictly higher
    priority_in = '0; set_prio(0, 3'd6); set_prio(3, 3'd6); req = 16'h0009;
    do_grant("sp_tie", 4'd0);
    priority_in = '0; set_prio(0, 3'd6); set_prio(15, 3'd7); req = 16'h8001;
    do_grant("sp_top", 4'd15);

    // WRR weighting: port 0 weight 2, port 1 weight 1
    sp0_wrr1 = 1'b1; priority_in = '0; set_prio(0, 3'd1); set_prio(1, 3'd0); req = 16'h0003;
    do_grant("wrr_a", 4'd0);
    do_grant("wrr_b", 4'd0);
    do_grant("wrr_c", 4'd1);
    do_grant("wrr_d", 4'd0);
    do_grant("wrr_e", 4'd0);
    do_grant("wrr_f", 4'd1);

    // Wrap: move rr_ptr to 15 via port 14, then 15 -> 0
    req = 16'h4000; set_prio(14, 3'd0);
    do_grant("wrap_14", 4'd14);
    req = 16'h8001; set_prio(15, 3'd0);
    do_grant("wrap_15", 4'd15);
    do_grant("wrap_0", 4'd0);

    // Grant held regardless of req, priority or mode changes
    sp0_wrr1 = 1'b0; priority_in = '0; req = 16'h0004;
    tick();
    chk("hold_port0", 32'(grant_port), 32'd2);
    req = 16'h0080; set_prio(7, 3'd7); sp0_wrr1 = 1'b1;
    tick();
    chk("hold_port1", 32'(grant_port), 32'd2);
    chk("hold_onehot", 32'(grant_onehot), 32'h0004);
    sp0_wrr1 = 1'b0;
    tick();
    chk("hold_port2", 32'(grant_port), 32'd2);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    req = '0;
    chk("hold_release", 32'(grant_valid), 32'd0);
    tick();
    chk("hold_stay_idle", 32'(grant_valid), 32'd0);

    // Reset mid-grant with credit 3 and rr_ptr 5
    sp0_wrr1 = 1'b1; priority_in = '0; req = 16'h0010;
    do_grant("pre_rst_4", 4'd4);
    set_prio(5, 3'd2); req = 16'h0021;
    tick();
    chk("pre_rst_5", 32'(grant_port), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(grant_valid), 32'd0);
    chk("midrst_port", 32'(grant_port), 32'd0);
    chk("midrst_onehot", 32'(grant_onehot), 32'd0);
    set_prio(0, 3'd1);
    do_grant("post_rst_a", 4'd0);
    do_grant("post_rst_b", 4'd0);
    do_grant("post_rst_c", 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
